axis_sync_fifo: RTL and testbench

Synchronous AXI-Stream FIFO that sits directly downstream of the AXI-Stream round-robin arbiter. It absorbs the arbiter's 8-bit `tdata`/`tlast` stream, so slave-side `tready` stalls no longer reach the arbitration stage. It presents the buffered beats to the downstream slave in first-word-fall-through order. It also reports occupancy, stored complete-packet count and an almost-full flag for flow-control monitoring.

---
 rtl/axis_pkg.sv | 25 ++
 rtl/axis_fifo_mem.sv | 34 +++
 rtl/axis_sync_fifo.sv | 134 +++++++++++++
 tb/tb_axis_sync_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkg
// Description : Shared AXI-Stream definitions (default data width and beat
//               record) for the arbiter, FIFO and later stream stages.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

  // Default tdata width used across the AXI-Stream path.
  localparam int AXIS_DATA_W = 8;

  // One stored beat: end-of-packet flag above the payload.
  typedef struct packed {
    logic                   last;
    logic [AXIS_DATA_W-1:0] data;
  } axis_beat_t;

  // Width of a packed beat record for a given payload width.
  function automatic int beat_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage : axis_pkg
`default_nettype wire

// File: rtl/axis_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_mem
// Description : DEPTH x WIDTH register array, synchronous write port and
//               asynchronous read port. Storage is intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the beat on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is a plain mux so the head beat falls through immediately.
  assign rdata_o = mem_q[raddr_i];

endmodule : axis_fifo_mem
`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_sync_fifo
// Description : First-word-fall-through AXI-Stream FIFO placed after the
//               round-robin arbiter. Decouples downstream tready stalls from
//               arbitration and reports occupancy, stored packet count and
//               an almost-full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W   = AXIS_DATA_W,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              Aclk,
  input  logic              Areset,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [CNT_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              almost_full
);

  localparam int              ADDR_W    = $clog2(DEPTH);
  localparam int              ENTRY_W   = beat_width(DATA_W);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]   pkt_q, pkt_d;

  logic               push;
  logic               pop;
  logic               pkt_in;
  logic               pkt_out;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // --------------------------------------------------------------------------
  // Handshake. Both readies/valids depend only on registered occupancy, so
  // there is no combinational path across the FIFO. Reset forces everything
  // visible to zero immediately, before the clearing edge arrives.
  // --------------------------------------------------------------------------
  assign s_axis_tready = (occ_q != FULL_CNT) && !Areset;
  assign m_axis_tvalid = (occ_q != '0) && !Areset;

  assign push    = s_axis_tvalid && s_axis_tready;
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign pkt_in  = push && s_axis_tlast;
  assign pkt_out = pop && m_axis_tlast;

  assign wr_entry = {s_axis_tlast, s_axis_tdata};

  // Head beat is zeroed when empty so stale memory never shows on the bus.
  assign m_axis_tdata = m_axis_tvalid ? rd_entry[DATA_W-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid ? rd_entry[DATA_W]     : 1'b0;

  assign occupancy   = Areset ? '0 : occ_q;
  assign pkt_count   = Areset ? '0 : pkt_q;
  assign almost_full = (occupancy >= AFULL_CNT);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  axis_fifo_mem #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (Aclk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Next-state for pointers and counters; pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (push && !pop) begin
      occ_d = occ_q + CNT_ONE;
    end else if (pop && !push) begin
      occ_d = occ_q - CNT_ONE;
    end

    if (pkt_in && !pkt_out) begin
      pkt_d = pkt_q + CNT_ONE;
    end else if (pkt_out && !pkt_in) begin
      pkt_d = pkt_q - CNT_ONE;
    end
  end

  // State registers; reset drops every stored beat, partial packets included.
  always_ff @(posedge Aclk) begin
    if (Areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
    end
  end

endmodule : axis_sync_fifo
`default_nettype wire

// File: tb/tb_axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_sync_fifo
// Description : Self-checking bench for axis_sync_fifo. Inputs change on the
//               falling edge; outputs are sampled 1 ns later, i.e. they show
//               the state the next rising edge will act upon.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_sync_fifo;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 8;
  localparam int AFULL_TH = 6;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  pkt;
  logic              afull;

  int n_checks = 0;
  int n_errors = 0;

  axis_sync_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH),
    .CNT_W    (CNT_W)
  ) dut (
    .Aclk          (clk),
    .Areset        (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .occupancy     (occ),
    .pkt_count     (pkt),
    .almost_full   (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sv;
    logic [7:0] sd;
    logic       sl;
    logic       mr;
    logic       e_sr;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_ml;
    int         e_occ;
    int         e_pkt;
    logic       e_af;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic sv, input logic [7:0] sd,
                              input logic sl, input logic mr,
                              input logic e_sr, input logic e_mv,
                              input logic [7:0] e_md, input logic e_ml,
                              input int e_occ, input int e_pkt, input logic e_af);
    vec_t v;
    v.rst = r;   v.sv = sv;     v.sd = sd;     v.sl = sl;     v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml;
    v.e_occ = e_occ; v.e_pkt = e_pkt; v.e_af = e_af;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive on the falling edge, settle, then let checks run.
  task automatic cyc(input logic r, input logic sv, input logic [7:0] sd,
                     input logic sl, input logic mr);
    @(negedge clk);
    rst     = r;
    s_valid = sv;
    s_data  = sd;
    s_last  = sl;
    m_ready = mr;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_sr, input logic e_mv,
                         input logic [7:0] e_md, input logic e_ml,
                         input int e_occ, input int e_pkt, input logic e_af);
    chk({tag, ".s_tready"}, int'(s_ready), int'(e_sr));
    chk({tag, ".m_tvalid"}, int'(m_valid), int'(e_mv));
    chk({tag, ".m_tdata"},  int'(m_data),  int'(e_md));
    chk({tag, ".m_tlast"},  int'(m_last),  int'(e_ml));
    chk({tag, ".occ"},      int'(occ),     e_occ);
    chk({tag, ".pkt"},      int'(pkt),     e_pkt);
    chk({tag, ".afull"},    int'(afull),   int'(e_af));
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;

    // Reset, idle, push three beats with the sink stalled, then drain.
    //                 rst sv  sd    sl mr   sr mv md    ml occ pkt af
    vecs.push_back(mk(1, 1, 8'hFF, 1, 1,   0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0,   1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 0,   1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 0,   1, 1, 8'h11, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h33, 1, 0,   1, 1, 8'h11, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0,   1, 1, 8'h11, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 1, 8'h11, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 1, 8'h22, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 1, 8'h33, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1,   1, 0, 8'h00, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].sv, vecs[i].sd, vecs[i].sl, vecs[i].mr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_sr, vecs[i].e_mv, vecs[i].e_md,
              vecs[i].e_ml, vecs[i].e_occ, vecs[i].e_pkt, vecs[i].e_af);
    end

    // Fill to full with the sink stalled; head stays on the first beat.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 8'(8'h40 + i), 0, 0);
      chk($sformatf("fill%0d.s_tready", i), int'(s_ready), 1);
      chk($sformatf("fill%0d.occ", i), int'(occ), i);
      chk($sformatf("fill%0d.afull", i), int'(afull), (i >= AFULL_TH) ? 1 : 0);
    end

    // 9th beat held off while full.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 8'hAA, 0, 0);
      chk_all($sformatf("full%0d", i), 0, 1, 8'h40, 0, 8, 0, 1);
    end

    // One-cycle pop with upstream valid held: the slot is taken next cycle.
    cyc(0, 1, 8'hAA, 0, 1);
    chk_all("fullpop", 0, 1, 8'h40, 0, 8, 0, 1);
    cyc(0, 1, 8'hAA, 0, 0);
    chk_all("refill", 1, 1, 8'h41, 0, 7, 0, 1);
    cyc(0, 0, 8'h00, 0, 0);
    chk_all("refull", 0, 1, 8'h41, 0, 8, 0, 1);

    // Drain: 0x41..0x47 then 0xAA exactly once.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 8'h00, 0, 1);
      chk($sformatf("drain%0d.m_tdata", i), int'(m_data),
          (i < DEPTH - 1) ? (8'h41 + i) : 8'hAA);
      chk($sformatf("drain%0d.occ", i), int'(occ), DEPTH - i);
    end
    cyc(0, 0, 8'h00, 0, 1);
    chk_all("drained", 1, 0, 8'h00, 0, 0, 0, 0);

    // Continuous stream of 20 beats; pointers wrap more than twice.
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 8'(k), (k == 19) ? 1'b1 : 1'b0, 1);
      if (k == 0) begin
        chk("stream0.m_tvalid", int'(m_valid), 0);
        chk("stream0.occ", int'(occ), 0);
      end else begin
        chk($sformatf("stream%0d.m_tdata", k), int'(m_data), k - 1);
        chk($sformatf("stream%0d.m_tvalid", k), int'(m_valid), 1);
        chk($sformatf("stream%0d.occ", k), int'(occ), 1);
      end
    end
    cyc(0, 0, 8'h00, 0, 1);
    chk_all("stream_tail", 1, 1, 8'h13, 1, 1, 1, 0);
    cyc(0, 0, 8'h00, 0, 1);
    chk_all("stream_done", 1, 0, 8'h00, 0, 0, 0, 0);

    // Five beats in two packets, then reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'(8'h61 + i), (i == 1 || i == 4) ? 1'b1 : 1'b0, 0);
    end
    cyc(0, 0, 8'h00, 0, 0);
    chk_all("pre_rst", 1, 1, 8'h61, 0, 5, 2, 0);
    cyc(1, 1, 8'hEE, 1, 1);
    chk_all("in_rst", 0, 0, 8'h00, 0, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 1);
    chk_all("post_rst", 1, 0, 8'h00, 0, 0, 0, 0);
    cyc(0, 1, 8'h5A, 1, 0);
    chk_all("push5a", 1, 0, 8'h00, 0, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk_all("head5a", 1, 1, 8'h5A, 1, 1, 1, 0);
    cyc(0, 0, 8'h00, 0, 1);
    chk_all("pop5a", 1, 1, 8'h5A, 1, 1, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk_all("empty_end", 1, 0, 8'h00, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_axis_sync_fifo
`default_nettype wire
